sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller port between three requesters: port 0 video scan-out, port 1 CPU, port 2 DMA/audio.
- Port 0 has fixed highest priority. Ports 1 and 2 alternate round-robin.
- Issues one transaction at a time to the controller and returns completion and read data to the owner.
- Sits between the SoC bus masters and the SDRAM controller, in the SDRAM clock domain.

---
 rtl/sdram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between video (0, fixed priority), CPU (1) and DMA (2).
// Ports 1/2 round-robin. Define ARB_TIMEOUT_EN to add an ack watchdog with a sticky err_o output.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [2:0]            req_i,
  input  logic [2:0]            we_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*DATA_W-1:0]   wdata_i,
  input  logic [3*DATA_W/8-1:0] wmask_i,
  output logic [2:0]            ack_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wmask_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
`ifdef ARB_TIMEOUT_EN
  output logic                  err_o,
`endif
  output logic                  busy_o,
  output logic [1:0]            owner_o
);

  localparam int MASK_W = DATA_W / 8;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_last_q, rr_last_d;
  logic [2:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          win;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  // Port 0 always wins; a 1-vs-2 tie goes to whichever did not win last.
  always_comb begin
    win = 2'd0;
    if (req_i[0])                  win = 2'd0;
    else if (req_i[1] && req_i[2]) win = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
    else if (req_i[1])             win = 2'd1;
    else if (req_i[2])             win = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    owner_d     = owner_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          mem_we_d    = we_i[win];
          mem_addr_d  = addr_i[win*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata_i[win*DATA_W +: DATA_W];
          mem_wmask_d = wmask_i[win*MASK_W +: MASK_W];
          mem_req_d   = 1'b1;
          owner_d     = win;
          if (win != 2'd0) rr_last_d = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata_i;
          ack_d     = 3'b001 << owner_q;
          state_d   = S_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          mem_req_d = 1'b0;
          rdata_d   = DATA_W'(32'hDEADBEEF);
          ack_d     = 3'b001 << owner_q;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // Requests are deliberately not sampled here so a held req cannot double-grant.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 2'd2;
      ack_q       <= 3'b000;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      owner_q     <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      owner_q     <= owner_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q != S_IDLE);
`ifdef ARB_TIMEOUT_EN
  assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: transaction-level grant model plus a randomized controller.
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
  logic err_o;
`else
  localparam int TO = 255;
`endif

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic [2:0]      req_i, we_i, ack_o;
  logic [3*AW-1:0] addr_i;
  logic [3*DW-1:0] wdata_i;
  logic [3*MW-1:0] wmask_i;
  logic [DW-1:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic            mem_req_o, mem_we_o, mem_ack_i, busy_o;
  logic [AW-1:0]   mem_addr_o;
  logic [MW-1:0]   mem_wmask_o;
  logic [1:0]      owner_o;

  int n_cmp = 0;
  int n_fail = 0;
  int m_last;
  logic          f_req[3];
  logic          f_we[3];
  logic [AW-1:0] f_addr[3];
  logic [DW-1:0] f_wdata[3];
  logic [MW-1:0] f_wmask[3];

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n_i(reset_n_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
`ifdef ARB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      req_i[k]              = f_req[k];
      we_i[k]               = f_we[k];
      addr_i[k*AW +: AW]    = f_addr[k];
      wdata_i[k*DW +: DW]   = f_wdata[k];
      wmask_i[k*MW +: MW]   = f_wmask[k];
    end
  endtask

  task automatic new_fields(input int k);
    f_we[k]    = 1'($urandom);
    f_addr[k]  = AW'($urandom);
    f_wdata[k] = $urandom;
    f_wmask[k] = MW'($urandom);
  endtask

  // Priority to port 0, otherwise the first requester of 1/2 scanning from just after the last winner.
  function automatic int pick(input logic [2:0] r, input int last);
    if (r[0]) return 0;
    for (int s = 1; s <= 2; s++) begin
      int p;
      p = ((last + s - 1) % 2) + 1;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n_i = 1'b0;
    mem_ack_i = 1'b0;
    for (int k = 0; k < 3; k++) begin f_req[k] = 1'b0; new_fields(k); end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    m_last = 2;
  endtask

  // Controller model: waits for a grant, checks it against the model, acks after dly cycles.
  task automatic serve(input int dly, output int port, output int edges);
    int exp;
    logic [DW-1:0] rd;
    edges = 0;
    port = -1;
    do begin
      @(posedge clk); #1; edges++;
    end while (!mem_req_o && edges < 50);
    n_cmp++;
    if (!mem_req_o) begin
      n_fail++;
      $display("FAIL grant_wait: mem_req_o=%0b after %0d cycles, required 1", mem_req_o, edges);
      return;
    end
    exp = pick(req_i, m_last);
    n_cmp++;
    if (exp < 0) begin
      n_fail++;
      $display("FAIL spurious_grant: owner_o=%0d granted with req_i=%b, required no grant", owner_o, req_i);
      return;
    end
    n_cmp++;
    if ({owner_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o} !==
        {2'(exp), f_we[exp], f_addr[exp], f_wdata[exp], f_wmask[exp]}) begin
      n_fail++;
      $display("FAIL grant_fields: owner=%0d we=%b addr=%h wdata=%h wmask=%h, required owner=%0d we=%b addr=%h wdata=%h wmask=%h",
               owner_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
               exp, f_we[exp], f_addr[exp], f_wdata[exp], f_wmask[exp]);
    end
    if (exp != 0) m_last = exp;
    repeat (dly) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_req_o, ack_o, busy_o} !== 5'b1_000_1) begin
        n_fail++;
        $display("FAIL wait_hold: mem_req=%b ack=%b busy=%b, required 1 000 1", mem_req_o, ack_o, busy_o);
      end
    end
    rd = $urandom;
    mem_ack_i = 1'b1;
    mem_rdata_i = rd;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;
    n_cmp++;
    if ({ack_o, rdata_o, mem_req_o} !== {3'b001 << exp, rd, 1'b0}) begin
      n_fail++;
      $display("FAIL ack: ack=%b rdata=%h mem_req=%b, required ack=%b rdata=%h mem_req=0",
               ack_o, rdata_o, mem_req_o, 3'b001 << exp, rd);
    end
    port = exp;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin f_req[k] = 1'b1; new_fields(k); end
    drive();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack_o, mem_req_o, busy_o, owner_o} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack=%b mem_req=%b busy=%b owner=%0d, required all 0", ack_o, mem_req_o, busy_o, owner_o);
    end
    n_cmp++;
    if ({rdata_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wmask=%h, required 0", rdata_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
    end
    mem_ack_i = 1'b0;
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    f_req[1] = 1'b1; f_we[1] = 1'b0; f_addr[1] = 24'h000100;
    drive();
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, owner_o} !== {1'b1, 1'b0, 24'h000100, 2'd1}) begin
      n_fail++;
      $display("FAIL single_issue: mem_req=%b we=%b addr=%h owner=%0d, required 1 0 000100 1", mem_req_o, mem_we_o, mem_addr_o, owner_o);
    end
    repeat (4) @(posedge clk);
    #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    f_req[1] = 1'b0; drive();
    n_cmp++;
    if ({ack_o, rdata_o} !== {3'b010, 32'h12345678}) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b rdata=%h, required 010 12345678", ack_o, rdata_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({ack_o, rdata_o, busy_o} !== {3'b000, 32'h12345678, 1'b0}) begin
      n_fail++;
      $display("FAIL single_after: ack=%b rdata=%h busy=%b, required 000 12345678 0", ack_o, rdata_o, busy_o);
    end
    m_last = 1;
  endtask

  task automatic test_all_three();
    int p, e;
    do_reset();
    for (int k = 0; k < 3; k++) begin f_req[k] = 1'b1; new_fields(k); end
    drive();
    for (int i = 0; i < 3; i++) begin
      serve($urandom_range(0, 3), p, e);
      if (p < 0) return;
      n_cmp++;
      if (p != i) begin
        n_fail++;
        $display("FAIL all_three_order: grant %0d went to port %0d, required %0d", i, p, i);
      end
      if (i > 0) begin
        n_cmp++;
        if (e != 2) begin
          n_fail++;
          $display("FAIL all_three_gap: mem_req rose %0d edges after mem_ack, required 2", e);
        end
      end
      f_req[p] = 1'b0;
      drive();
    end
  endtask

  task automatic test_round_robin();
    int p, e;
    int rem[3];
    do_reset();
    rem = '{0, 4, 4};
    for (int k = 1; k < 3; k++) begin f_req[k] = 1'b1; new_fields(k); end
    drive();
    for (int i = 0; i < 8; i++) begin
      serve($urandom_range(0, 3), p, e);
      if (p < 0) return;
      n_cmp++;
      if (p != ((i % 2 == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL rr_order: grant %0d went to port %0d, required %0d", i, p, (i % 2 == 0) ? 1 : 2);
      end
      if (i > 0) begin
        n_cmp++;
        if (e != 2) begin
          n_fail++;
          $display("FAIL rr_gap: mem_req rose %0d edges after mem_ack, required 2", e);
        end
      end
      if (p > 0) rem[p]--;
      if (rem[p] <= 0) f_req[p] = 1'b0;
      else new_fields(p);
      drive();
    end
  endtask

  task automatic test_write_hold();
    int p, e, grants;
    do_reset();
    f_req[1] = 1'b1; f_we[1] = 1'b1; f_addr[1] = 24'h00ABCD;
    f_wdata[1] = 32'hCAFEF00D; f_wmask[1] = 4'b0011;
    drive();
    serve(2, p, e);
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req_o, ack_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL hold_done: mem_req=%b ack=%b busy=%b, required 0 000 0", mem_req_o, ack_o, busy_o);
    end
    f_req[1] = 1'b0;
    drive();
    grants = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_req_o) grants++;
    end
    n_cmp++;
    if (grants != 0) begin
      n_fail++;
      $display("FAIL hold_dup: %0d extra cycles with mem_req_o high, required 0", grants);
    end
  endtask

  task automatic test_reset_mid();
    int p, e;
    do_reset();
    new_fields(2); f_req[2] = 1'b1;
    drive();
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req_o, owner_o} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL mid_issue: mem_req=%b owner=%0d, required 1 2", mem_req_o, owner_o);
    end
    @(posedge clk); #1;
    reset_n_i = 1'b0;
    f_req[2] = 1'b0; drive();
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    m_last = 2;
    n_cmp++;
    if ({mem_req_o, ack_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset: mem_req=%b ack=%b busy=%b, required 0 000 0", mem_req_o, ack_o, busy_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack_o !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_no_ack: ack=%b, required 000", ack_o);
    end
    for (int k = 1; k < 3; k++) begin f_req[k] = 1'b1; new_fields(k); end
    drive();
    for (int i = 1; i < 3; i++) begin
      serve(1, p, e);
      if (p < 0) return;
      n_cmp++;
      if (p != i) begin
        n_fail++;
        $display("FAIL mid_contest: grant went to port %0d, required %0d", p, i);
      end
      f_req[p] = 1'b0;
      drive();
    end
  endtask

  task automatic test_random();
    int p, e;
    do_reset();
    f_req[$urandom_range(0, 2)] = 1'b1;
    drive();
    for (int i = 0; i < 40; i++) begin
      serve($urandom_range(0, 4), p, e);
      if (p < 0) return;
      f_req[p] = 1'b0;
      for (int k = 0; k < 3; k++)
        if (!f_req[k] && $urandom_range(0, 2) != 0) begin f_req[k] = 1'b1; new_fields(k); end
      if (!(f_req[0] || f_req[1] || f_req[2])) begin
        p = $urandom_range(0, 2);
        f_req[p] = 1'b1; new_fields(p);
      end
      drive();
    end
    for (int k = 0; k < 3; k++) f_req[k] = 1'b0;
    drive();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, p, e;
    do_reset();
    new_fields(2); f_we[2] = 1'b0; f_req[2] = 1'b1;
    drive();
    @(posedge clk); #1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (ack_o == 3'b000 && cyc < 40);
    n_cmp++;
    if (cyc != 9) begin
      n_fail++;
      $display("FAIL timeout_latency: ack after %0d cycles, required 9", cyc);
    end
    n_cmp++;
    if ({ack_o, rdata_o, err_o, mem_req_o} !== {3'b100, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_ack: ack=%b rdata=%h err=%b mem_req=%b, required 100 deadbeef 1 0", ack_o, rdata_o, err_o, mem_req_o);
    end
    f_req[2] = 1'b0; new_fields(1); f_req[1] = 1'b1;
    drive();
    serve(2, p, e);
    f_req[1] = 1'b0; drive();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b, required 1", err_o);
    end
    do_reset();
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b, required 0", err_o);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    m_last = 2;
    for (int k = 0; k < 3; k++) begin f_req[k] = 1'b0; new_fields(k); end
    drive();
    test_reset();
    test_single_read();
    test_all_three();
    test_round_robin();
    test_write_hold();
    test_reset_mid();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
